// File: rtl/snake_growth_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : snake_growth_controller_if
// Description : Control/status bundle between the game logic and the snake
//               growth controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface snake_growth_controller_if;
   logic       i_start_btn;
   logic       i_food_eaten;
   logic       i_collision;
   logic       i_step_tick;
   logic       o_grow_out;
   logic       o_parts_clear;
   logic [3:0] o_length;
   logic [1:0] o_pending;
   logic       o_running;
   logic       o_game_over;
   logic       o_win;

   // Game side: drives the events, observes the status.
   modport master (
      output i_start_btn, i_food_eaten, i_collision, i_step_tick,
      input  o_grow_out, o_parts_clear, o_length, o_pending,
      input  o_running, o_game_over, o_win
   );

   // Controller side.
   modport slave (
      input  i_start_btn, i_food_eaten, i_collision, i_step_tick,
      output o_grow_out, o_parts_clear, o_length, o_pending,
      output o_running, o_game_over, o_win
   );
endinterface
`default_nettype wire

// File: rtl/snake_growth_controller.sv
`default_nettype none
// ============================================================================
// Module      : snake_growth_controller
// Description : Queues food events as grow requests and issues isolated
//               one-cycle grow strobes on game steps, tracking snake length
//               up to a win at length 10. Collision ends the game.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_growth_controller (
   input  wire                            clk,
   input  wire                            rst,   // synchronous, active low
   snake_growth_controller_if.slave       bus
);

   localparam logic [3:0] C_MAX_LEN   = 4'd10;
   localparam logic [1:0] C_MAX_PEND  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_GROW_HI = 3'd2,
      S_GROW_LO = 3'd3,
      S_OVER    = 3'd4,
      S_WIN     = 3'd5
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [3:0] r_length;
   logic [3:0] w_length_next;
   logic [1:0] r_pending;
   logic [1:0] w_pending_next;
   logic       r_start_prev;
   logic       r_food_prev;
   logic       r_grow;
   logic       r_clear;
   logic       r_running;
   logic       r_over;
   logic       r_win;

   logic       w_start_edge;
   logic       w_food_edge;
   logic [1:0] w_pending_inc;

   assign w_start_edge  = bus.i_start_btn  & ~r_start_prev;
   assign w_food_edge   = bus.i_food_eaten & ~r_food_prev;
   assign w_pending_inc = (r_pending == C_MAX_PEND) ? C_MAX_PEND : r_pending + 2'd1;

   // Next-state, length and grow-queue decisions; collision outranks growth.
   always_comb begin
      w_state_next   = r_state;
      w_length_next  = r_length;
      w_pending_next = r_pending;
      case (r_state)
         S_IDLE: begin
            w_length_next  = 4'd1;
            w_pending_next = 2'd0;
            if (w_start_edge) w_state_next = S_RUN;
         end
         S_RUN: begin
            if (bus.i_collision) begin
               w_state_next   = S_OVER;
               w_pending_next = 2'd0;
            end else if (bus.i_step_tick && (r_pending != 2'd0) && (r_length < C_MAX_LEN)) begin
               // A simultaneous food edge cancels the decrement (+1-1).
               w_state_next   = S_GROW_HI;
               w_length_next  = r_length + 4'd1;
               w_pending_next = w_food_edge ? r_pending : r_pending - 2'd1;
            end else if (w_food_edge) begin
               w_pending_next = w_pending_inc;
            end
         end
         S_GROW_HI: begin
            if (bus.i_collision) begin
               w_state_next   = S_OVER;
               w_pending_next = 2'd0;
            end else begin
               w_state_next = S_GROW_LO;
               if (w_food_edge) w_pending_next = w_pending_inc;
            end
         end
         S_GROW_LO: begin
            if (bus.i_collision) begin
               w_state_next   = S_OVER;
               w_pending_next = 2'd0;
            end else if (r_length == C_MAX_LEN) begin
               w_state_next   = S_WIN;
               w_pending_next = 2'd0;
            end else begin
               w_state_next = S_RUN;
               if (w_food_edge) w_pending_next = w_pending_inc;
            end
         end
         S_OVER, S_WIN: begin
            w_pending_next = 2'd0;
            if (w_start_edge) begin
               w_state_next  = S_IDLE;
               w_length_next = 4'd1;
            end
         end
         default: begin
            w_state_next   = S_IDLE;
            w_length_next  = 4'd1;
            w_pending_next = 2'd0;
         end
      endcase
   end

   // State, counters, edge history and registered output flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_length     <= 4'd1;
         r_pending    <= 2'd0;
         // Loading 1 keeps an input held through reset from looking like an edge.
         r_start_prev <= 1'b1;
         r_food_prev  <= 1'b1;
         r_grow       <= 1'b0;
         r_clear      <= 1'b1;
         r_running    <= 1'b0;
         r_over       <= 1'b0;
         r_win        <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_length     <= w_length_next;
         r_pending    <= w_pending_next;
         r_start_prev <= bus.i_start_btn;
         r_food_prev  <= bus.i_food_eaten;
         // GROW_HI is only ever entered from RUN, so this is a single-cycle strobe.
         r_grow       <= (w_state_next == S_GROW_HI);
         r_clear      <= (w_state_next == S_IDLE);
         r_running    <= (w_state_next == S_RUN) || (w_state_next == S_GROW_HI) ||
                         (w_state_next == S_GROW_LO);
         r_over       <= (w_state_next == S_OVER);
         r_win        <= (w_state_next == S_WIN);
      end
   end

   assign bus.o_grow_out    = r_grow;
   assign bus.o_parts_clear = r_clear;
   assign bus.o_length      = r_length;
   assign bus.o_pending     = r_pending;
   assign bus.o_running     = r_running;
   assign bus.o_game_over   = r_over;
   assign bus.o_win         = r_win;

endmodule
`default_nettype wire

// File: tb/tb_snake_growth_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_growth_controller
// Description : Self-checking bench for snake_growth_controller with a
//               game-level reference model and a downstream segment counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_growth_controller;

   logic clk = 1'b0;
   logic rst = 1'b0;

   snake_growth_controller_if bus ();

   snake_growth_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 playing, 2 over, 3 won.
   // m_cool counts the remaining cycles of a grow sequence (2 = pulse cycle).
   int m_mode, m_len, m_pend, m_cool;
   bit m_pf, m_ps;
   int checks = 0;
   int passed = 0;
   int cyc    = 0;
   // Model of the downstream segment counter fed by grow_out / parts_clear.
   int   ds_cnt  = 0;
   logic ds_prev = 1'b0;

   task automatic model_update(input logic r, s, f, c, t);
      bit fe, se, grow;
      if (!r) begin
         m_mode = 0; m_len = 1; m_pend = 0; m_cool = 0; m_pf = 1; m_ps = 1;
      end else begin
         fe = f && !m_pf;
         se = s && !m_ps;
         m_pf = f;
         m_ps = s;
         case (m_mode)
            0: if (se) m_mode = 1;
            1: begin
               if (c) begin
                  m_mode = 2; m_pend = 0; m_cool = 0;
               end else if (m_cool == 1 && m_len == 10) begin
                  m_mode = 3; m_pend = 0; m_cool = 0;
               end else begin
                  grow = (m_cool == 0) && t && (m_pend > 0) && (m_len < 10);
                  m_pend = m_pend + (fe ? 1 : 0) - (grow ? 1 : 0);
                  if (m_pend > 3) m_pend = 3;
                  if (grow) begin
                     m_len  = m_len + 1;
                     m_cool = 2;
                  end else if (m_cool > 0) begin
                     m_cool = m_cool - 1;
                  end
               end
            end
            default: if (se) begin
               m_mode = 0; m_len = 1; m_pend = 0;
            end
         endcase
      end
   endtask

   function automatic logic [10:0] exp_vec();
      return {(m_cool == 2), (m_mode == 0), 4'(m_len), 2'(m_pend),
              (m_mode == 1), (m_mode == 2), (m_mode == 3)};
   endfunction

   function automatic logic [10:0] act_vec();
      return {bus.o_grow_out, bus.o_parts_clear, bus.o_length, bus.o_pending,
              bus.o_running, bus.o_game_over, bus.o_win};
   endfunction

   // One clock: apply inputs, advance model at the edge, settle, update counter.
   task automatic step(input logic r, s, f, c, t);
      rst              = r;
      bus.i_start_btn  = s;
      bus.i_food_eaten = f;
      bus.i_collision  = c;
      bus.i_step_tick  = t;
      @(posedge clk);
      model_update(r, s, f, c, t);
      #1;
      cyc++;
      if (bus.o_parts_clear) ds_cnt = 0;
      else if (bus.o_grow_out && !ds_prev) ds_cnt++;
      ds_prev = bus.o_grow_out;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   // Reset then start a fresh game.
   task automatic restart();
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
   endtask

   task automatic food_edge();
      step(1, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 0, 1);
         checks++;
         if (act_vec() !== exp_vec()) $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, act_vec(), exp_vec());
         else passed++;
      end
      // Start held high through reset must not start the game.
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 0, 0);
         checks++;
         if (act_vec() !== exp_vec()) $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, act_vec(), exp_vec());
         else passed++;
      end
      checks++;
      if (bus.o_parts_clear !== 1'b1 || bus.o_length !== 4'd1)
         $display("FAIL reset_idle clear=%b len=%0d required clear=1 len=1", bus.o_parts_clear, bus.o_length);
      else passed++;
   endtask

   task automatic test_basic_grow();
      int pulses = 0;
      restart();
      food_edge();
      food_edge();
      checks++;
      if (bus.o_pending !== 2'd2) $display("FAIL basic_pending got=%0d required=2", bus.o_pending);
      else passed++;
      for (int k = 0; k < 2; k++) begin
         step(1, 0, 0, 0, 1);
         if (bus.o_grow_out) pulses++;
         checks++;
         if (act_vec() !== exp_vec()) $display("FAIL basic_grow cyc=%0d got=%b exp=%b", cyc, act_vec(), exp_vec());
         else passed++;
         for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0);
            if (bus.o_grow_out) pulses++;
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL basic_gap cyc=%0d got=%b exp=%b", cyc, act_vec(), exp_vec());
            else passed++;
         end
      end
      checks++;
      if (pulses !== 2 || bus.o_length !== 4'd3 || bus.o_pending !== 2'd0)
         $display("FAIL basic_total pulses=%0d len=%0d pend=%0d required 2/3/0", pulses, bus.o_length, bus.o_pending);
      else passed++;
   endtask

   task automatic test_saturation();
      restart();
      for (int i = 0; i < 5; i++) food_edge();
      checks++;
      if (bus.o_pending !== 2'd3) $display("FAIL sat_pending got=%0d required=3", bus.o_pending);
      else passed++;
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 0, 0, 1);
         checks++;
         if (act_vec() !== exp_vec()) $display("FAIL sat_tick cyc=%0d got=%b exp=%b", cyc, act_vec(), exp_vec());
         else passed++;
         idle_n(3);
      end
      checks++;
      if (bus.o_length !== 4'd4 || ds_cnt !== 3)
         $display("FAIL sat_len len=%0d grows=%0d required len=4 grows=3", bus.o_length, ds_cnt);
      else passed++;
   endtask

   task automatic test_win();
      restart();
      for (int k = 0; k < 9; k++) begin
         food_edge();
         step(1, 0, 0, 0, 1);
         idle_n(3);
      end
      checks++;
      if (act_vec() !== exp_vec() || bus.o_win !== 1'b1 || bus.o_length !== 4'd10)
         $display("FAIL win_state got=%b exp=%b", act_vec(), exp_vec());
      else passed++;
      for (int k = 0; k < 4; k++) begin
         step(1, 0, 1, 1, 1);
         step(1, 0, 0, 0, 1);
         checks++;
         if (act_vec() !== exp_vec() || bus.o_grow_out !== 1'b0)
            $display("FAIL win_hold cyc=%0d got=%b exp=%b", cyc, act_vec(), exp_vec());
         else passed++;
      end
      checks++;
      if (ds_cnt !== 9) $display("FAIL win_downstream got=%0d required=9", ds_cnt);
      else passed++;
   endtask

   task automatic test_collision();
      restart();
      food_edge();
      step(1, 0, 0, 1, 1);
      checks++;
      if (bus.o_game_over !== 1'b1 || bus.o_grow_out !== 1'b0 || bus.o_length !== 4'd1 ||
          act_vec() !== exp_vec())
         $display("FAIL collision got=%b exp=%b", act_vec(), exp_vec());
      else passed++;
      step(1, 0, 1, 0, 1);
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL collision_hold got=%b exp=%b", act_vec(), exp_vec());
      else passed++;
   endtask

   task automatic test_reset_mid_grow();
      restart();
      food_edge();
      step(1, 0, 0, 0, 1);
      checks++;
      if (bus.o_grow_out !== 1'b1) $display("FAIL midgrow_enter grow=%b required=1", bus.o_grow_out);
      else passed++;
      step(0, 1, 0, 0, 0);
      checks++;
      if (bus.o_grow_out !== 1'b0 || bus.o_parts_clear !== 1'b1 || bus.o_length !== 4'd1)
         $display("FAIL midgrow_reset got=%b required grow=0 clear=1 len=1", act_vec());
      else passed++;
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 0, 0);
         checks++;
         if (act_vec() !== exp_vec() || bus.o_running !== 1'b0)
            $display("FAIL midgrow_held cyc=%0d got=%b exp=%b", cyc, act_vec(), exp_vec());
         else passed++;
      end
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      checks++;
      if (bus.o_running !== 1'b1 || act_vec() !== exp_vec())
         $display("FAIL midgrow_repress got=%b exp=%b", act_vec(), exp_vec());
      else passed++;
   endtask

   task automatic test_over_restart();
      restart();
      food_edge();
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 1, 0);
      checks++;
      if (bus.o_game_over !== 1'b1 || bus.o_length !== 4'd2 || act_vec() !== exp_vec())
         $display("FAIL over_enter got=%b exp=%b", act_vec(), exp_vec());
      else passed++;
      step(1, 1, 0, 0, 0);
      checks++;
      if (bus.o_parts_clear !== 1'b1 || act_vec() !== exp_vec())
         $display("FAIL over_to_idle got=%b exp=%b", act_vec(), exp_vec());
      else passed++;
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      checks++;
      if (bus.o_running !== 1'b1 || bus.o_length !== 4'd1 || act_vec() !== exp_vec())
         $display("FAIL over_restart got=%b exp=%b", act_vec(), exp_vec());
      else passed++;
   endtask

   task automatic test_random();
      logic r, s, f, c, t;
      restart();
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 199) != 0);
         s = ($urandom_range(0, 19) == 0);
         f = ($urandom_range(0, 2) == 0);
         c = ($urandom_range(0, 39) == 0);
         t = ($urandom_range(0, 2) == 0);
         step(r, s, f, c, t);
         checks++;
         if (act_vec() !== exp_vec() || ds_cnt != int'(bus.o_length) - 1 || ds_cnt > 9)
            $display("FAIL random cyc=%0d got=%b exp=%b grows=%0d", cyc, act_vec(), exp_vec(), ds_cnt);
         else passed++;
      end
   endtask

   initial begin
      bus.i_start_btn  = 1'b0;
      bus.i_food_eaten = 1'b0;
      bus.i_collision  = 1'b0;
      bus.i_step_tick  = 1'b0;
      test_reset();
      test_basic_grow();
      test_saturation();
      test_win();
      test_collision();
      test_reset_mid_grow();
      test_over_restart();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
